// File: rtl/seg_scan_if.sv
// Bundle of the display-data inputs and segment/digit outputs of seg_scan.
// master = timing/data source side, slave = the seg_scan driver itself.
interface seg_scan_if #(
  parameter int digit_count = 8
);
  logic                     phase [0:digit_count-1];
  logic [4*digit_count-1:0] value;
  logic [digit_count-1:0]   dp_in;
  logic [digit_count-1:0]   blink_en;
  logic                     lz_en;
  logic                     update;
  logic [digit_count-1:0]   digit_n;
  logic [7:0]               seg_n;
  logic                     frame_start;
  logic                     phase_error;

  modport master (
    output phase, value, dp_in, blink_en, lz_en, update,
    input  digit_n, seg_n, frame_start, phase_error
  );

  modport slave (
    input  phase, value, dp_in, blink_en, lz_en, update,
    output digit_n, seg_n, frame_start, phase_error
  );
endinterface

// File: rtl/seg_scan.sv
// Multiplexed 7-segment driver. Follows the one-hot phase vector from the
// timing stage, lighting one digit per phase from a per-frame snapshot of
// the display data, with anti-ghost blanking, leading-zero suppression and
// per-digit blink. All outputs are registered (one cycle behind phase).
module seg_scan #(
  parameter int digit_count  = 8,
  parameter int blank_cycles = 1,
  parameter int blink_frames = 32
) (
  input logic       clock,
  input logic       reset_n,
  seg_scan_if.slave bus
);

  localparam int iw = (digit_count > 1) ? $clog2(digit_count) : 1;
  localparam int bw = (blank_cycles > 0) ? $clog2(blank_cycles + 1) : 1;
  localparam int fw = (blink_frames > 1) ? $clog2(blink_frames) : 1;

  localparam logic [iw-1:0] last_idx   = iw'(digit_count - 1);
  localparam logic [bw-1:0] blank_load = bw'(blank_cycles);
  localparam logic [fw-1:0] frame_top  = fw'(blink_frames - 1);

  logic [iw-1:0]            prev_idx_q;
  logic [bw-1:0]            blank_cnt_q,   blank_cnt_d;
  logic [fw-1:0]            frame_cnt_q,   frame_cnt_d;
  logic                     blink_phase_q, blink_phase_d;
  logic                     pending_q,     pending_d;
  logic [4*digit_count-1:0] shadow_val_q,  shadow_val_d;
  logic [digit_count-1:0]   shadow_dp_q,   shadow_dp_d;
  logic [digit_count-1:0]   shadow_blink_q, shadow_blink_d;
  logic [digit_count-1:0]   digit_n_q,     digit_n_d;
  logic [7:0]               seg_n_q,       seg_n_d;
  logic                     frame_start_q;
  logic                     phase_error_q;

  logic                   seen, multi, valid, change, boundary, load, lit;
  logic                   zero_above;
  logic [iw-1:0]          idx;
  logic [bw-1:0]          blank_eff;
  logic [digit_count-1:0] sup_vec;
  logic [3:0]             nibble;
  logic [6:0]             pattern;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Phase decode, snapshot/blink/blank next-state and the next digit/segment drive.
  // Display uses the _d shadow/blink values so the boundary cycle already shows the new frame.
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    idx   = '0;
    for (int i = 0; i < digit_count; i++) begin
      if (bus.phase[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
        idx  = iw'(i);
      end
    end
    valid    = seen && !multi;
    change   = valid && (idx != prev_idx_q);
    boundary = change && (idx == '0);

    blank_eff = change ? blank_load : blank_cnt_q;
    if (!valid)                blank_cnt_d = blank_cnt_q;
    else if (blank_eff != '0)  blank_cnt_d = blank_eff - 1'b1;
    else                       blank_cnt_d = '0;

    load           = boundary && (pending_q || bus.update);
    shadow_val_d   = load ? bus.value    : shadow_val_q;
    shadow_dp_d    = load ? bus.dp_in    : shadow_dp_q;
    shadow_blink_d = load ? bus.blink_en : shadow_blink_q;
    if (boundary)        pending_d = 1'b0;
    else if (bus.update) pending_d = 1'b1;
    else                 pending_d = pending_q;

    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (boundary) begin
      if (frame_cnt_q == '0) begin
        frame_cnt_d   = frame_top;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q - 1'b1;
      end
    end

    zero_above = 1'b1;
    sup_vec    = '0;
    for (int k = digit_count - 1; k >= 1; k--) begin
      zero_above = zero_above && (shadow_val_d[4*k +: 4] == 4'h0);
      sup_vec[k] = bus.lz_en && zero_above;
    end

    nibble  = shadow_val_d[4*idx +: 4];
    pattern = sup_vec[idx] ? 7'h00 : hex7(nibble);
    lit     = valid && (blank_eff == '0) && !(shadow_blink_d[idx] && blink_phase_d);

    if (lit) begin
      digit_n_d = ~(digit_count'(1) << idx);
      seg_n_d   = ~{shadow_dp_d[idx], pattern};
    end else begin
      digit_n_d = '1;
      seg_n_d   = 8'hFF;
    end
  end

  // State and output registers; invalid phase leaves prev_idx and counters untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_idx_q     <= last_idx;
      blank_cnt_q    <= '0;
      frame_cnt_q    <= frame_top;
      blink_phase_q  <= 1'b0;
      pending_q      <= 1'b1;
      shadow_val_q   <= '0;
      shadow_dp_q    <= '0;
      shadow_blink_q <= '0;
      digit_n_q      <= '1;
      seg_n_q        <= 8'hFF;
      frame_start_q  <= 1'b0;
      phase_error_q  <= 1'b0;
    end else begin
      if (valid) prev_idx_q <= idx;
      blank_cnt_q    <= blank_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      blink_phase_q  <= blink_phase_d;
      pending_q      <= pending_d;
      shadow_val_q   <= shadow_val_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blink_q <= shadow_blink_d;
      digit_n_q      <= digit_n_d;
      seg_n_q        <= seg_n_d;
      frame_start_q  <= boundary;
      phase_error_q  <= !valid;
    end
  end

  assign bus.digit_n     = digit_n_q;
  assign bus.seg_n       = seg_n_q;
  assign bus.frame_start = frame_start_q;
  assign bus.phase_error = phase_error_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: the driver pushes the expected next-cycle
// outputs from a behavioural model; a monitor pops and compares each cycle.
module tb_seg_scan;
  localparam int dc        = 8;
  localparam int blank_cyc = 1;
  localparam int blink_fr  = 2;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  seg_scan_if #(.digit_count(dc)) bus ();

  seg_scan #(
    .digit_count (dc),
    .blank_cycles(blank_cyc),
    .blink_frames(blink_fr)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] dn;
    logic [7:0] sn;
    logic       fs;
    logic       pe;
  } exp_t;

  exp_t exp_q[$];

  // model state, expressed in terms of the observable rules
  int          m_prev;
  int          m_since;
  int          m_nbound;
  bit          m_pending;
  logic [31:0] m_val;
  logic [7:0]  m_dp;
  logic [7:0]  m_blink;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tbl[n];
  endfunction

  task automatic model_reset();
    m_prev    = dc - 1;
    m_since   = blank_cyc;
    m_nbound  = 0;
    m_pending = 1'b1;
    m_val     = '0;
    m_dp      = '0;
    m_blink   = '0;
  endtask

  task automatic model_step(input logic [7:0] ph, input logic upd);
    exp_t       e;
    int         idx, hi;
    bit         valid, change, boundary, lit, blink_now, sup;
    logic [6:0] pat;
    valid = ($countones(ph) == 1);
    idx   = 0;
    for (int i = 0; i < dc; i++) if (ph[i]) idx = i;
    change   = valid && (idx != m_prev);
    boundary = change && (idx == 0);
    if (boundary) begin
      m_nbound++;
      if (m_pending || upd) begin
        m_val   = bus.value;
        m_dp    = bus.dp_in;
        m_blink = bus.blink_en;
      end
      m_pending = 1'b0;
    end else if (upd) begin
      m_pending = 1'b1;
    end
    if (change) m_since = 0;
    else if (valid && m_since < 1000) m_since++;
    if (valid) m_prev = idx;
    blink_now = m_blink[idx] && (((m_nbound / blink_fr) % 2) == 1);
    lit = valid && (m_since >= blank_cyc) && !blink_now;
    hi = 0;
    for (int k = 0; k < dc; k++) if (m_val[4*k +: 4] != 4'h0) hi = k;
    sup = bus.lz_en && (idx > hi);
    pat = sup ? 7'h00 : seg_of(m_val[4*idx +: 4]);
    e.dn = lit ? ~(8'h01 << idx) : 8'hFF;
    e.sn = lit ? ~{m_dp[idx], pat} : 8'hFF;
    e.fs = boundary;
    e.pe = !valid;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [7:0] ph, input logic upd);
    for (int i = 0; i < dc; i++) bus.phase[i] = ph[i];
    bus.update = upd;
    model_step(ph, upd);
    @(posedge clock);
    #2;
    bus.update = 1'b0;
  endtask

  task automatic run_frame(input int dwell, input logic upd_first);
    for (int d = 0; d < dc; d++)
      for (int c = 0; c < dwell; c++)
        step(8'h01 << d, upd_first && d == 0 && c == 0);
  endtask

  task automatic apply_reset(input int cycles);
    exp_t r;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.digit_n !== 8'hFF || bus.seg_n !== 8'hFF || bus.frame_start !== 1'b0
        || bus.phase_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_dark digit_n=%h seg_n=%h fs=%b pe=%b expected FF FF 0 0",
               bus.digit_n, bus.seg_n, bus.frame_start, bus.phase_error);
    end
    model_reset();
    r = '{dn: 8'hFF, sn: 8'hFF, fs: 1'b0, pe: 1'b0};
    for (int i = 0; i < cycles; i++) begin
      exp_q.push_back(r);
      @(posedge clock);
      #2;
    end
    reset_n = 1'b1;
  endtask

  // monitor: every cycle the registered outputs are compared with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.digit_n !== e.dn || bus.seg_n !== e.sn || bus.frame_start !== e.fs
            || bus.phase_error !== e.pe) begin
          errors++;
          $display("FAIL out t=%0t digit_n=%h seg_n=%h fs=%b pe=%b expected digit_n=%h seg_n=%h fs=%b pe=%b",
                   $time, bus.digit_n, bus.seg_n, bus.frame_start, bus.phase_error,
                   e.dn, e.sn, e.fs, e.pe);
        end
      end
    end
  end

  initial begin
    logic [7:0] ph;
    int         dw;
    reset_n      = 1'b0;
    for (int i = 0; i < dc; i++) bus.phase[i] = 1'b0;
    bus.value    = '0;
    bus.dp_in    = '0;
    bus.blink_en = '0;
    bus.lz_en    = 1'b0;
    bus.update   = 1'b0;
    model_reset();
    @(posedge clock);
    #2;
    apply_reset(2);

    // basic scan: digit k shows hex(k)
    bus.value = 32'h76543210;
    run_frame(4, 1'b1);
    run_frame(4, 1'b0);
    run_frame(4, 1'b0);

    // mid-frame update only takes effect at the next boundary
    for (int d = 0; d < dc; d++)
      for (int c = 0; c < 4; c++) begin
        if (d == 3 && c == 1) bus.value = $urandom;
        step(8'h01 << d, d == 3 && c == 1);
      end
    run_frame(4, 1'b0);

    // leading-zero suppression
    bus.lz_en = 1'b1;
    bus.value = 32'h00000450;
    bus.dp_in = 8'h88;
    run_frame(3, 1'b1);
    run_frame(3, 1'b0);
    bus.value = 32'h0;
    run_frame(3, 1'b1);
    run_frame(3, 1'b0);
    bus.lz_en = 1'b0;
    bus.dp_in = 8'h00;

    // blink on digit 0
    bus.blink_en = 8'h01;
    bus.value    = $urandom;
    run_frame(2, 1'b1);
    for (int f = 0; f < 6; f++) run_frame(2, 1'b0);
    bus.blink_en = 8'h00;

    // invalid phases: zero and multi-hot, then recovery
    step(8'h01, 1'b1);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    step(8'h03, 1'b0);
    step(8'h01, 1'b0);
    step(8'h02, 1'b0);
    step(8'h02, 1'b0);
    step(8'hFF, 1'b0);
    step(8'h02, 1'b0);
    run_frame(3, 1'b0);

    // reset mid-digit: first phase[0] afterwards reloads without update
    step(8'h01, 1'b0);
    step(8'h02, 1'b0);
    step(8'h02, 1'b0);
    bus.value = $urandom;
    bus.dp_in = 8'($urandom);
    apply_reset(2);
    run_frame(3, 1'b0);
    run_frame(3, 1'b0);

    // randomized traffic
    for (int f = 0; f < 40; f++) begin
      dw = $urandom_range(1, 5);
      if ($urandom_range(0, 2) == 0) begin
        bus.value    = $urandom;
        bus.dp_in    = 8'($urandom);
        bus.blink_en = 8'($urandom);
        if ($urandom_range(0, 1) == 0) bus.value[31:16] = 16'h0;
      end
      bus.lz_en = 1'($urandom_range(0, 1));
      for (int d = 0; d < dc; d++)
        for (int c = 0; c < dw; c++) begin
          if ($urandom_range(0, 11) == 0) begin
            ph = 8'($urandom);
            if ($countones(ph) == 1) ph = 8'h00;
            step(ph, 1'($urandom_range(0, 5) == 0));
          end
          step(8'h01 << d, 1'($urandom_range(0, 15) == 0));
        end
    end

    @(posedge clock);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
